ex_divider: RTL and testbench
=============================

// Module: ex_divider
// PURPOSE
//  Iterative RV32M divide unit in EX stage; consumes the ALU operand pair s1/s2 (dividend/divisor)
//  and returns DIV/DIVU/REM/REMU result. Radix-2 restoring, one quotient bit per cycle.
//  Holds the pipeline via div_stall until the result is valid, then hands it to the EX result mux.
// PARAMETERS
//  XLEN  32  operand/result width; iteration counter width = $clog2(XLEN)+1
// PORTS
//  clk           in   1     clock, all state updates on rising edge
//  rst           in   1     synchronous, active-high reset
//  IDEX_DivEn    in   1     divide op present in EX; held high until div_valid
//  IDEX_DivOp    in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU; stable while IDEX_DivEn high
//  IDEX_Flush    in   1     kill in-flight op (branch/trap), synchronous
//  s1            in   XLEN  dividend (ALU operand 1); sampled on accept edge only
//  s2            in   XLEN  divisor  (ALU operand 2); sampled on accept edge only
//  div_stall     out  1     comb: IDEX_DivEn & ~div_valid; freezes IF/ID/EX
//  div_valid     out  1     registered, one-cycle pulse, div_result valid
//  div_result    out  XLEN  registered quotient or remainder; holds until next accept
// BEHAVIOUR
//  - Reset: state IDLE, div_valid 0, div_result 0, counter 0, internal regs 0.
//  - FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//    IDLE: on edge with IDEX_DivEn=1 & IDEX_Flush=0 ("accept edge" E0): latch op, |s1|,|s2|
//      (abs only for signed ops), sign flags, special-case flags; counter=XLEN; go CALC.
//    CALC: each edge shift {rem,quo} left 1, trial-subtract divisor, set quotient bit if no
//      borrow; counter-1; leave for FIX on the edge where counter reaches 0 (edges E1..E32).
//    FIX: sign correction + special cases written to div_result (edge E33); go DONE.
//    DONE: div_valid=1 for this single cycle; IDEX_DivEn still high is ignored; next edge -> IDLE.
//  - Latency: XLEN+2 edges from accept to div_valid (34 for XLEN=32); throughput 1 op / XLEN+3.
//  - Back-to-back: pipeline advances in DONE cycle; a new DivEn seen in IDLE next cycle is accepted.
//  - Signs: quotient negated if signed op & sign(s1)!=sign(s2); remainder takes sign of s1.
//  - Div by zero: DIV/DIVU quotient = all ones (-1); REM/REMU = s1 unchanged.
//  - Overflow (DIV/REM only): s1=0x8000_0000, s2=0xFFFF_FFFF -> DIV 0x8000_0000, REM 0.
//  - Special cases override FIX datapath result; arithmetic internally XLEN+1 bits for borrow.
//  - IDEX_Flush or rst in any state: next edge IDLE, div_valid 0, div_result unchanged
//    (rst: cleared); flush has priority over accept in the same cycle.
//  - Operand changes on s1/s2 after accept have no effect.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined: div-by-zero, signed overflow, and |s1|<|s2| skip CALC:
//    accept edge -> FIX directly; div_valid 2 edges after accept (result per rules above;
//    |s1|<|s2| gives quotient 0, remainder s1).
//  Not defined: every op takes full XLEN+2 latency; results identical, timing fixed.
// TESTING
//  1 DIVU s1=100 s2=7 -> div_result 14, div_valid exactly 34 cycles after accept, one cycle wide.
//  2 DIV s1=-7 s2=2 -> 0xFFFF_FFFD (-3); REM same operands -> 0xFFFF_FFFF (-1).
//  3 DIV s1=5 s2=0 -> 0xFFFF_FFFF; REMU s1=5 s2=0 -> 5; with DIV_EARLY_OUT_EN valid 2 cycles after accept.
//  4 DIV s1=0x8000_0000 s2=-1 -> 0x8000_0000; REM -> 0.
//  5 Flush at cycle 10 of CALC -> no div_valid, IDLE next cycle; new DIVU 9/3 -> 3 at full latency.
//  6 Back-to-back REMU 17/5 then DIVU 17/5, DivEn held across -> 2 then 3, valids 35 cycles apart.

Source files
------------

// File: rtl/ex_divider.sv
// Iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Optional build macro DIV_EARLY_OUT_EN: div-by-zero, signed overflow and |s1|<|s2| skip iteration.
module ex_divider #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            IDEX_DivEn,
    input  logic [1:0]      IDEX_DivOp,
    input  logic            IDEX_Flush,
    input  logic [XLEN-1:0] s1,
    input  logic [XLEN-1:0] s2,
    output logic            div_stall,
    output logic            div_valid,
    output logic [XLEN-1:0] div_result
);
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dvsr_q;
    logic [XLEN-1:0]   dvnd_q;
    logic              is_rem_q;
    logic              quo_neg_q;
    logic              rem_neg_q;
    logic              div0_q;
    logic              ovf_q;
    logic              div_valid_q;
    logic [XLEN-1:0]   div_result_q;

    // Accept-time operand conditioning: magnitudes only for signed ops.
    logic              op_signed;
    logic [XLEN-1:0]   abs_s1;
    logic [XLEN-1:0]   abs_s2;
    logic              in_div0;
    logic              in_ovf;
    logic              early_c;

    assign op_signed = ~IDEX_DivOp[0];
    assign abs_s1    = (op_signed && s1[XLEN-1]) ? (~s1 + XLEN'(1)) : s1;
    assign abs_s2    = (op_signed && s2[XLEN-1]) ? (~s2 + XLEN'(1)) : s2;
    assign in_div0   = (s2 == '0);
    assign in_ovf    = op_signed && (s1 == MIN_NEG) && (s2 == '1);

`ifdef DIV_EARLY_OUT_EN
    assign early_c = in_div0 | in_ovf | (abs_s1 < abs_s2);
`else
    assign early_c = 1'b0;
`endif

    // One restoring step: shift {rem,quo}, trial-subtract with an extra borrow bit.
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     trial;
    logic              no_borrow;
    logic [XLEN-1:0]   rem_d;
    logic [XLEN-1:0]   quo_d;

    assign shifted   = {rem_q, quo_q[XLEN-1]};
    assign trial     = shifted - {1'b0, dvsr_q};
    assign no_borrow = ~trial[XLEN];
    assign rem_d     = no_borrow ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_d     = {quo_q[XLEN-2:0], no_borrow};

    // Sign correction with special cases taking precedence.
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result_d;

    assign quo_fix = quo_neg_q ? (~quo_q + XLEN'(1)) : quo_q;
    assign rem_fix = rem_neg_q ? (~rem_q + XLEN'(1)) : rem_q;

    always_comb begin
        result_d = is_rem_q ? rem_fix : quo_fix;
        if (div0_q) begin
            result_d = is_rem_q ? dvnd_q : '1;
        end else if (ovf_q) begin
            result_d = is_rem_q ? '0 : MIN_NEG;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvsr_q       <= '0;
            dvnd_q       <= '0;
            is_rem_q     <= 1'b0;
            quo_neg_q    <= 1'b0;
            rem_neg_q    <= 1'b0;
            div0_q       <= 1'b0;
            ovf_q        <= 1'b0;
            div_valid_q  <= 1'b0;
            div_result_q <= '0;
        end else begin
            div_valid_q <= 1'b0;
            if (IDEX_Flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (IDEX_DivEn) begin
                            is_rem_q  <= IDEX_DivOp[1];
                            quo_neg_q <= op_signed & (s1[XLEN-1] ^ s2[XLEN-1]);
                            rem_neg_q <= op_signed & s1[XLEN-1];
                            div0_q    <= in_div0;
                            ovf_q     <= in_ovf;
                            dvnd_q    <= s1;
                            dvsr_q    <= abs_s2;
                            cnt_q     <= CNT_W'(XLEN);
                            if (early_c) begin
                                // quotient 0, remainder |s1| -- exact when |s1|<|s2|
                                rem_q   <= abs_s1;
                                quo_q   <= '0;
                                state_q <= FIX;
                            end else begin
                                rem_q   <= '0;
                                quo_q   <= abs_s1;
                                state_q <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= FIX;
                        end
                    end
                    FIX: begin
                        div_result_q <= result_d;
                        div_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign div_valid  = div_valid_q;
    assign div_result = div_result_q;
    assign div_stall  = IDEX_DivEn & ~div_valid_q;

endmodule

// File: tb/tb_ex_divider.sv
// Directed self-checking bench for ex_divider: results, latency, flush and back-to-back behaviour.
module tb_ex_divider;
    localparam int XLEN     = 32;
    localparam int FULL_LAT = 34;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 34;
`endif
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic            clk;
    logic            rst;
    logic            div_en;
    logic [1:0]      div_op;
    logic            flush;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            div_stall;
    logic            div_valid;
    logic [XLEN-1:0] div_result;

    int n_checks;
    int n_errors;
    int cyc;
    int valid_cyc;

    ex_divider #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .IDEX_DivEn (div_en),
        .IDEX_DivOp (div_op),
        .IDEX_Flush (flush),
        .s1         (op_a),
        .s2         (op_b),
        .div_stall  (div_stall),
        .div_valid  (div_valid),
        .div_result (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op; latency counts posedges from the accept edge (inclusive) to valid.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input bit hold);
        int lat;
        bit got;
        @(negedge clk);
        div_en = 1'b1;
        div_op = op;
        op_a   = a;
        op_b   = b;
        lat    = 0;
        got    = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                check({tag, "_stall"}, 32'(div_stall), 32'd1);
                op_a = $urandom;
                op_b = $urandom;
            end
            if (div_valid) got = 1'b1;
        end
        valid_cyc = cyc;
        check({tag, "_seen"}, 32'(got), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, div_result, exp);
        check({tag, "_nostall"}, 32'(div_stall), 32'd0);
        if (!hold) div_en = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(div_valid), 32'd0);
    endtask

    task automatic watch_no_valid(input string tag, input int n);
        int hits;
        hits = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (div_valid) hits++;
        end
        check(tag, 32'(hits), 32'd0);
    endtask

    initial begin
        int c1;
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b1;
        div_en = 1'b0;
        div_op = 2'b00;
        flush  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(div_valid), 32'd0);
        check("rst_result", div_result, 32'd0);
        check("rst_stall", 32'(div_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT, 1'b0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FULL_LAT, 1'b0);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FULL_LAT, 1'b0);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, FULL_LAT, 1'b0);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, FULL_LAT, 1'b0);
        run_op("remu_max_16", OP_REMU, 32'hFFFF_FFFF, 32'd16, 32'd15, FULL_LAT, 1'b0);
        run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, FULL_LAT, 1'b0);
        run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, EARLY_LAT, 1'b0);
        run_op("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, EARLY_LAT, 1'b0);
        run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, EARLY_LAT, 1'b0);
        run_op("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, EARLY_LAT, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EARLY_LAT, 1'b0);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EARLY_LAT, 1'b0);
        run_op("divu_3_10", OP_DIVU, 32'd3, 32'd10, 32'd0, EARLY_LAT, 1'b0);
        run_op("rem_m3_10", OP_REM, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, EARLY_LAT, 1'b0);
        run_op("remu_min_max", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
               EARLY_LAT, 1'b0);

        // Flush ten edges into CALC: op dies, previous result stays.
        @(negedge clk);
        div_en = 1'b1;
        div_op = OP_DIVU;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush  = 1'b1;
        div_en = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        watch_no_valid("flush_calc_novalid", 40);
        check("flush_result_held", div_result, 32'h8000_0000);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, FULL_LAT, 1'b0);

        // Flush wins over accept on the same edge.
        @(negedge clk);
        div_en = 1'b1;
        div_op = OP_DIVU;
        op_a   = 32'd50;
        op_b   = 32'd5;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        flush  = 1'b0;
        div_en = 1'b0;
        watch_no_valid("flush_accept_novalid", 40);

        // Back-to-back with DivEn held through DONE.
        run_op("b2b_remu", OP_REMU, 32'd17, 32'd5, 32'd2, FULL_LAT, 1'b1);
        c1 = valid_cyc;
        run_op("b2b_divu", OP_DIVU, 32'd17, 32'd5, 32'd3, FULL_LAT, 1'b0);
        check("b2b_spacing", 32'(valid_cyc - c1), 32'd35);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
